// File: rtl/pe_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : pe_cfg_loader
// Brief   : Configuration sequencer for the PE array. Parses a packetised
//           32-bit stream (header + payload words) arriving on a valid/ready
//           handshake. Each payload word is replayed onto the addressed PE's
//           {valid,data} configure port for one cycle, in stream order.
// Revision: 1.0 - initial release
// ============================================================================
module pe_cfg_loader #(
    parameter int NUM_PE = 3,
    parameter int CFG_W  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          cfg_in_valid,
    output logic                          cfg_in_ready,
    input  logic [31:0]                   cfg_in_data,
    output logic [NUM_PE*(CFG_W+1)-1:0]   cfg_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int         c_slice_w = CFG_W + 1;
    localparam logic [8:0] c_num_pe  = 9'(NUM_PE);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_header  = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_finish  = 2'd3;

    logic [1:0]                        r_state;
    logic [1:0]                        w_state_nxt;
    logic [7:0]                        r_pe_id;
    logic [7:0]                        r_count;
    logic                              r_last;
    logic                              r_done;
    logic                              r_err;
    logic [NUM_PE*(CFG_W+1)-1:0]       r_cfg_out;

    logic                              w_ready;
    logic                              w_accept;
    logic                              w_hdr_acc;
    logic                              w_pay_acc;
    logic                              w_pe_ok;
    logic [7:0]                        w_hdr_pe_id;
    logic [7:0]                        w_hdr_count;
    logic                              w_hdr_last;
    logic [CFG_W-1:0]                  w_word;

    // Header field extraction; bits [14:0] of a header carry nothing.
    assign w_hdr_pe_id = cfg_in_data[31:24];
    assign w_hdr_count = cfg_in_data[23:16];
    assign w_hdr_last  = cfg_in_data[15];

    // Adapt the 32-bit stream word to the configure data width.
    generate
        if (CFG_W <= 32) begin : g_word_narrow
            assign w_word = cfg_in_data[CFG_W-1:0];
        end else begin : g_word_wide
            assign w_word = {{(CFG_W-32){1'b0}}, cfg_in_data};
        end
    endgenerate

    assign w_ready   = (r_state == c_st_header) || (r_state == c_st_payload);
    assign w_accept  = cfg_in_valid && w_ready;
    assign w_hdr_acc = w_accept && (r_state == c_st_header);
    assign w_pay_acc = w_accept && (r_state == c_st_payload);
    // Out-of-range PE ids still consume their payload but never drive a port.
    assign w_pe_ok   = ({1'b0, r_pe_id} < c_num_pe);

    assign cfg_in_ready = w_ready;
    assign busy         = w_ready;
    assign done         = r_done;
    assign err          = r_err;
    assign cfg_out      = r_cfg_out;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: packets chain header->payload until a last packet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_header;
                end
            end
            c_st_header: begin
                if (w_hdr_acc) begin
                    if (w_hdr_count != 8'd0) begin
                        w_state_nxt = c_st_payload;
                    end else if (w_hdr_last) begin
                        w_state_nxt = c_st_finish;
                    end else begin
                        w_state_nxt = c_st_header;
                    end
                end
            end
            c_st_payload: begin
                if (w_pay_acc && (r_count == 8'd1)) begin
                    w_state_nxt = r_last ? c_st_finish : c_st_header;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Packet context, session status flags and payload countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pe_id <= 8'd0;
            r_count <= 8'd0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) && start) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_hdr_acc) begin
                r_pe_id <= w_hdr_pe_id;
                r_count <= w_hdr_count;
                r_last  <= w_hdr_last;
                if ({1'b0, w_hdr_pe_id} >= c_num_pe) begin
                    r_err <= 1'b1;
                end
            end
            // Payload state is only entered with count >= 1, so no wrap.
            if (w_pay_acc) begin
                r_count <= r_count - 8'd1;
            end
            if ((r_state != c_st_finish) && (w_state_nxt == c_st_finish)) begin
                r_done <= 1'b1;
            end
        end
    end

    // One-cycle registered replay of each accepted payload word to its PE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_out <= '0;
        end else begin
            r_cfg_out <= '0;
            if (w_pay_acc && w_pe_ok) begin
                for (int i = 0; i < NUM_PE; i++) begin
                    if (r_pe_id == 8'(i)) begin
                        r_cfg_out[i*c_slice_w +: c_slice_w] <= {1'b1, w_word};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_cfg_loader
// Brief   : Directed self-checking bench for pe_cfg_loader (NUM_PE=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pe_cfg_loader;

    localparam int NUM_PE = 3;
    localparam int CFG_W  = 32;
    localparam int SW     = CFG_W + 1;

    logic                        clk;
    logic                        reset;
    logic                        start;
    logic                        cfg_in_valid;
    logic                        cfg_in_ready;
    logic [31:0]                 cfg_in_data;
    logic [NUM_PE*SW-1:0]        cfg_out;
    logic                        busy;
    logic                        done;
    logic                        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int bad    = 0;

    logic [31:0] q   [NUM_PE][$];
    int          q_t [NUM_PE][$];

    pe_cfg_loader #(.NUM_PE(NUM_PE), .CFG_W(CFG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_in_valid (cfg_in_valid),
        .cfg_in_ready (cfg_in_ready),
        .cfg_in_data  (cfg_in_data),
        .cfg_out      (cfg_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to timestamp observed configure words.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid word per PE; flag nonzero data without valid.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (cfg_out[i*SW + CFG_W] === 1'b1) begin
                q[i].push_back(cfg_out[i*SW +: CFG_W]);
                q_t[i].push_back(cyc);
            end else if (cfg_out[i*SW +: CFG_W] !== '0 && !$isunknown(cfg_out)) begin
                bad = bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < NUM_PE; i++) begin
            q[i].delete();
            q_t[i].delete();
        end
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word, wait (bounded) for ready, let it be accepted.
    task automatic send(input logic [31:0] w, input bit gap);
        int n;
        n = 0;
        cfg_in_valid = 1'b1;
        cfg_in_data  = w;
        while (!cfg_in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready_timeout", 128'(n < 20), 128'd1);
        tick();
        cfg_in_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic run_two_packets(input bit gap);
        start_session();
        send(32'h0102_0000, gap);
        send(32'd1, gap);
        if (gap) chk("t3_gap_zero", 128'(cfg_out), 128'd0);
        send(32'd12, gap);
        send(32'h0202_8000, gap);
        send(32'd1, gap);
        send(32'd5, gap);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        cfg_in_valid = 1'b0;
        cfg_in_data  = 32'd0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 128'(cfg_in_ready), 128'd0);
        chk("rst_busy",  128'(busy), 128'd0);
        chk("rst_done",  128'(done), 128'd0);
        chk("rst_err",   128'(err), 128'd0);
        chk("rst_cfg",   128'(cfg_out), 128'd0);
        tick();

        // 1: single word to PE0
        clear_q();
        start_session();
        chk("t1_busy", 128'(busy), 128'd1);
        chk("t1_ready_hdr", 128'(cfg_in_ready), 128'd1);
        send(32'h0001_8000, 1'b0);
        chk("t1_hdr_not_fwd", 128'(cfg_out), 128'd0);
        send(32'd8, 1'b0);
        chk("t1_cfg", 128'(cfg_out), 128'h1_0000_0008);
        chk("t1_done", 128'(done), 128'd1);
        chk("t1_busy_fin", 128'(busy), 128'd0);
        chk("t1_ready_fin", 128'(cfg_in_ready), 128'd0);
        tick();
        chk("t1_cfg_after", 128'(cfg_out), 128'd0);
        chk("t1_done_held", 128'(done), 128'd1);
        tick();
        chk("t1_done_held2", 128'(done), 128'd1);

        // 2: two packets, valid held high
        clear_q();
        run_two_packets(1'b0);
        chk("t2_done", 128'(done), 128'd1);
        chk("t2_ready_fin", 128'(cfg_in_ready), 128'd0);
        tick();
        chk("t2_pe0_n", 128'(q[0].size()), 128'd0);
        chk("t2_pe1_n", 128'(q[1].size()), 128'd2);
        chk("t2_pe2_n", 128'(q[2].size()), 128'd2);
        if (q[1].size() == 2 && q[2].size() == 2) begin
            chk("t2_pe1_w0", 128'(q[1][0]), 128'd1);
            chk("t2_pe1_w1", 128'(q[1][1]), 128'd12);
            chk("t2_pe2_w0", 128'(q[2][0]), 128'd1);
            chk("t2_pe2_w1", 128'(q[2][1]), 128'd5);
            chk("t2_pe1_consec", 128'(q_t[1][1] - q_t[1][0]), 128'd1);
            chk("t2_pe2_consec", 128'(q_t[2][1] - q_t[2][0]), 128'd1);
            chk("t2_pkt_gap", 128'(q_t[2][0] - q_t[1][1]), 128'd2);
        end
        tick();

        // 3: same stream with valid toggling
        clear_q();
        run_two_packets(1'b1);
        chk("t3_done", 128'(done), 128'd1);
        chk("t3_pe0_n", 128'(q[0].size()), 128'd0);
        chk("t3_pe1_n", 128'(q[1].size()), 128'd2);
        chk("t3_pe2_n", 128'(q[2].size()), 128'd2);
        if (q[1].size() == 2 && q[2].size() == 2) begin
            chk("t3_pe1_w0", 128'(q[1][0]), 128'd1);
            chk("t3_pe1_w1", 128'(q[1][1]), 128'd12);
            chk("t3_pe2_w0", 128'(q[2][0]), 128'd1);
            chk("t3_pe2_w1", 128'(q[2][1]), 128'd5);
            chk("t3_pe1_spacing", 128'(q_t[1][1] - q_t[1][0]), 128'd2);
        end
        tick();

        // 4: out-of-range pe_id
        clear_q();
        start_session();
        chk("t4_err_clr", 128'(err), 128'd0);
        send(32'h0703_8000, 1'b0);
        chk("t4_err_hdr", 128'(err), 128'd1);
        send(32'hAAAA_0001, 1'b0);
        send(32'hAAAA_0002, 1'b0);
        chk("t4_busy_mid", 128'(busy), 128'd1);
        send(32'hAAAA_0003, 1'b0);
        chk("t4_err", 128'(err), 128'd1);
        chk("t4_done", 128'(done), 128'd1);
        chk("t4_cfg", 128'(cfg_out), 128'd0);
        tick();
        chk("t4_no_words", 128'(q[0].size() + q[1].size() + q[2].size()), 128'd0);

        // 5: count 0 last header, also verifies start clears err and done
        clear_q();
        start_session();
        chk("t5_err_cleared", 128'(err), 128'd0);
        chk("t5_done_cleared", 128'(done), 128'd0);
        send(32'h0000_8000, 1'b0);
        chk("t5_done", 128'(done), 128'd1);
        chk("t5_busy", 128'(busy), 128'd0);
        tick();
        chk("t5_no_words", 128'(q[0].size() + q[1].size() + q[2].size()), 128'd0);

        // 6: reset mid-packet (start asserted with reset too), then reload
        clear_q();
        start_session();
        send(32'h0004_8000, 1'b0);
        send(32'h0000_000A, 1'b0);
        send(32'h0000_000B, 1'b0);
        reset        = 1'b1;
        start        = 1'b1;
        cfg_in_valid = 1'b1;
        cfg_in_data  = 32'h0000_000C;
        tick();
        reset        = 1'b0;
        start        = 1'b0;
        cfg_in_valid = 1'b0;
        chk("t6_ready", 128'(cfg_in_ready), 128'd0);
        chk("t6_busy",  128'(busy), 128'd0);
        chk("t6_done",  128'(done), 128'd0);
        chk("t6_cfg",   128'(cfg_out), 128'd0);
        tick();
        chk("t6_idle_ready", 128'(cfg_in_ready), 128'd0);
        chk("t6_pe0_n", 128'(q[0].size()), 128'd2);
        if (q[0].size() == 2) begin
            chk("t6_pe0_w0", 128'(q[0][0]), 128'hA);
            chk("t6_pe0_w1", 128'(q[0][1]), 128'hB);
        end
        clear_q();
        start_session();
        send(32'h0101_8000, 1'b0);
        send(32'h0000_0077, 1'b0);
        chk("t6_reload_cfg", 128'(cfg_out), 128'h0000_0001_0000_0077 << SW);
        chk("t6_reload_done", 128'(done), 128'd1);
        tick();
        chk("t6_reload_pe1_n", 128'(q[1].size()), 128'd1);
        chk("no_stray_data", 128'(bad), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
